riscv_mem_responder: RTL and testbench

//  - Memory-side responder for the RV32I multicycle core's unified instruction/data port.
//  - Serves core reads (address, r_en_mem -> MemData) and core writes (address, data_out, w_en_mem).
//  - Adds configurable read latency and a mem_ready handshake. The core stalls its FSM until mem_ready.
//  - Sits at top level between the core and a single-port word array.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/mem_word_array.sv | 38 +++
 rtl/riscv_mem_responder.sv | 157 +++++++++++++++
 tb/tb_riscv_mem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I memory responder: FSM state encoding,
// the fault data pattern and the latency counter width.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Data returned for a read that falls outside the array
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Width of the read latency down-counter (READ_LATENCY up to 15)
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array, DEPTH_WORDS x 32, with four byte-write enables.
// Writes are synchronous; reads land in an output register that holds its
// value until the next read enable. Only the output register is reset, the
// storage itself is left untouched.
module mem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write: each strobe bit updates its own 8-bit lane
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read port; holds the last word read until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the RV32I multicycle core's unified port.
// Accepts one read or write in IDLE, models a configurable read latency,
// and signals completion with a one-cycle mem_ready pulse.
// Optional feature macro: MEM_ERR_EN -- when defined, addresses with any
// bit set above the array index range fault (no write, read returns
// ERR_DATA, mem_err=1 with mem_ready). When undefined the index wraps.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [3:0]  w_strb,
  input  logic        r_en_mem,
  input  logic        w_en_mem,
  output logic [31:0] MemData,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(READ_LATENCY - 1);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

  state_t state;
  state_t state_nxt;

  logic [LAT_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]    idx_p1;
  logic                 rd_oor_p1;
  logic                 data_err;
  logic                 resp_err;

  logic [ADDR_W-1:0]    req_idx;
  logic                 req_oor;
  logic                 accept_wr;
  logic                 accept_rd;

  logic [ADDR_W-1:0]    arr_addr;
  logic [3:0]           arr_we;
  logic                 arr_re;
  logic [31:0]          arr_rdata;

  // Byte offset is the load unit's concern; upper bits only matter for faults
  logic unused_addr;
  assign unused_addr = ^{address[31:ADDR_W+2], address[1:0]};

  assign req_idx = address[ADDR_W+1:2];

`ifdef MEM_ERR_EN
  assign req_oor = |address[31:ADDR_W+2];
`else
  assign req_oor = 1'b0;
`endif

  assign accept_wr = (state == IDLE) && w_en_mem;
  assign accept_rd = (state == IDLE) && r_en_mem && !w_en_mem;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: write wins a collision; reads wait out the latency
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (w_en_mem) begin
          state_nxt = RESP;
        end else if (r_en_mem) begin
          state_nxt = (CNT_INIT == '0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_ONE) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: completion pulse and array port control
  always_comb begin
    mem_ready = (state == RESP);
    arr_we    = (accept_wr && !req_oor) ? w_strb : 4'b0000;
    arr_re    = (accept_rd && (CNT_INIT == '0)) ||
                ((state == BUSY) && (cnt == CNT_ONE));
    arr_addr  = (state == BUSY) ? idx_p1 : req_idx;
  end

  // Latency counter and fault flags for the transaction in flight
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt       <= '0;
      rd_oor_p1 <= 1'b0;
      data_err  <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_en_mem) begin
            resp_err <= req_oor;
          end else if (r_en_mem) begin
            cnt       <= CNT_INIT;
            rd_oor_p1 <= req_oor;
            resp_err  <= req_oor;
            if (CNT_INIT == '0) begin
              data_err <= req_oor;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            data_err <= rd_oor_p1;
          end
        end
        default: ;
      endcase
    end
  end

  // Word index captured at read accept; later address changes are ignored
  always_ff @(posedge clk_in) begin
    if (accept_rd) begin
      idx_p1 <= req_idx;
    end
  end

  assign MemData = data_err ? ERR_DATA : arr_rdata;
  assign mem_err = mem_ready & resp_err;

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk_in),
    .rst   (rst_in),
    .addr  (arr_addr),
    .we    (arr_we),
    .wdata (data_in),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed scenarios plus
// randomized traffic checked against a word-array reference model.
module tb_riscv_mem_responder;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in;
  logic [31:0] address, data_in, MemData;
  logic [3:0]  w_strb;
  logic        r_en_mem, w_en_mem, mem_ready, mem_err;

  logic [31:0] address_b, data_in_b, MemData_b;
  logic [3:0]  w_strb_b;
  logic        r_en_b, w_en_b, mem_ready_b, mem_err_b;

  riscv_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .address(address), .data_in(data_in),
    .w_strb(w_strb), .r_en_mem(r_en_mem), .w_en_mem(w_en_mem),
    .MemData(MemData), .mem_ready(mem_ready), .mem_err(mem_err));

  riscv_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .address(address_b), .data_in(data_in_b),
    .w_strb(w_strb_b), .r_en_mem(r_en_b), .w_en_mem(w_en_b),
    .MemData(MemData_b), .mem_ready(mem_ready_b), .mem_err(mem_err_b));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [1024];
  bit          model_known [1024];
  logic [31:0] last_read;

  function automatic bit addr_oor(logic [31:0] a);
`ifdef MEM_ERR_EN
    return (a[31:12] != 20'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    int i;
    i = int'(a[11:2]);
    if (addr_oor(a)) return;
    for (int b = 0; b < 4; b++) if (s[b]) model_mem[i][8*b +: 8] = d[8*b +: 8];
    if (s == 4'hF) model_known[i] = 1'b1;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (addr_oor(a)) return 32'hDEAD_BEEF;
    return model_mem[int'(a[11:2])];
  endfunction

  // One request on the latency-2 instance; lat is cycles from accept to mem_ready (0 = timeout)
  task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] q, output logic e, output int lat);
    @(negedge clk_in);
    address = a; data_in = d; w_strb = s; w_en_mem = wr; r_en_mem = rd;
    @(posedge clk_in); #1;
    w_en_mem = 1'b0; r_en_mem = 1'b0;
    address = $urandom;
    lat = 0; q = 'x; e = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      if (mem_ready === 1'b1) begin
        lat = i; q = MemData; e = mem_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] q; logic e; int lat; int seen;
    rst_in = 1'b1;
    address = '0; data_in = '0; w_strb = 4'hF; r_en_mem = 0; w_en_mem = 0;
    address_b = '0; data_in_b = '0; w_strb_b = 4'hF; r_en_b = 0; w_en_b = 0;
    repeat (2) @(negedge clk_in);
    vectors++; if (MemData !== 32'h0) begin miscompares++; $display("FAIL reset_memdata got %h expected %h", MemData, 32'h0); end
    vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b expected 0", mem_ready); end
    vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b expected 0", mem_err); end
    vectors++; if (MemData_b !== 32'h0) begin miscompares++; $display("FAIL reset_memdata_b got %h expected %h", MemData_b, 32'h0); end
    rst_in = 1'b0;
    txn(1, 0, 32'h44, 32'hCAFE_F00D, 4'hF, q, e, lat);
    model_write(32'h44, 32'hCAFE_F00D, 4'hF);
    txn(0, 1, 32'h44, 32'h0, 4'hF, q, e, lat);
    vectors++; if (q !== model_read(32'h44)) begin miscompares++; $display("FAIL prereset_read got %h expected %h", q, model_read(32'h44)); end
    // start a read, then reset while it is in BUSY
    @(negedge clk_in);
    address = 32'h44; r_en_mem = 1'b1;
    @(posedge clk_in); #1;
    r_en_mem = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    vectors++; if (MemData !== 32'h0) begin miscompares++; $display("FAIL midbusy_memdata got %h expected %h", MemData, 32'h0); end
    vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL midbusy_ready got %b expected 0", mem_ready); end
    @(negedge clk_in);
    rst_in = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk_in);
      if (mem_ready === 1'b1) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL dropped_read_ready got %0d pulses expected 0", seen); end
    last_read = 32'h0;
  endtask

  task automatic test_write_read();
    logic [31:0] q; logic e; int lat;
    txn(1, 0, 32'h40, 32'h1234_5678, 4'hF, q, e, lat);
    model_write(32'h40, 32'h1234_5678, 4'hF);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL write_latency got %0d expected 1", lat); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL write_err got %b expected 0", e); end
    txn(0, 1, 32'h40, 32'h0, 4'hF, q, e, lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL read_latency got %0d expected 2", lat); end
    vectors++; if (q !== 32'h1234_5678) begin miscompares++; $display("FAIL read_data got %h expected %h", q, 32'h1234_5678); end
    last_read = q;
  endtask

  task automatic test_byte_strobes();
    logic [31:0] q; logic e; int lat;
    txn(1, 0, 32'h80, 32'hAABB_CCDD, 4'hF, q, e, lat);
    model_write(32'h80, 32'hAABB_CCDD, 4'hF);
    txn(1, 0, 32'h80, 32'h1122_3344, 4'b0101, q, e, lat);
    model_write(32'h80, 32'h1122_3344, 4'b0101);
    txn(0, 1, 32'h82, 32'h0, 4'hF, q, e, lat);
    vectors++; if (q !== model_read(32'h80)) begin miscompares++; $display("FAIL strobe_read got %h expected %h", q, model_read(32'h80)); end
    vectors++; if (q !== 32'hAA22_CC44) begin miscompares++; $display("FAIL strobe_value got %h expected %h", q, 32'hAA22_CC44); end
    last_read = q;
  endtask

  task automatic test_collision();
    logic [31:0] q; logic e; int lat;
    txn(0, 1, 32'h40, 32'h0, 4'hF, q, e, lat);
    last_read = model_read(32'h40);
    txn(1, 1, 32'h10, 32'h5A5A_5A5A, 4'hF, q, e, lat);
    model_write(32'h10, 32'h5A5A_5A5A, 4'hF);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL collision_latency got %0d expected 1", lat); end
    vectors++; if (q !== last_read) begin miscompares++; $display("FAIL collision_memdata got %h expected %h", q, last_read); end
    txn(0, 1, 32'h10, 32'h0, 4'hF, q, e, lat);
    vectors++; if (q !== 32'h5A5A_5A5A) begin miscompares++; $display("FAIL collision_followup got %h expected %h", q, 32'h5A5A_5A5A); end
    last_read = q;
  endtask

  task automatic test_held_request();
    logic [31:0] v;
    bit prev;
    v = $urandom;
    @(negedge clk_in);
    address_b = 32'h20; data_in_b = v; w_strb_b = 4'hF; w_en_b = 1'b1;
    @(posedge clk_in); #1;
    w_en_b = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    r_en_b = 1'b1;
    prev = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      vectors++;
      if (mem_ready_b !== ((k % 2) == 1)) begin
        miscompares++; $display("FAIL held_ready_cycle%0d got %b expected %b", k, mem_ready_b, (k % 2) == 1);
      end
      if (prev && mem_ready_b === 1'b1) begin
        miscompares++; $display("FAIL held_consecutive_cycle%0d got ready twice expected single pulse", k);
      end
      if (mem_ready_b === 1'b1) begin
        vectors++; if (MemData_b !== v) begin miscompares++; $display("FAIL held_data_cycle%0d got %h expected %h", k, MemData_b, v); end
      end
      prev = (mem_ready_b === 1'b1);
    end
    r_en_b = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] q; logic e; int lat; logic [31:0] w;
    w = $urandom;
    txn(1, 0, 32'h0, 32'h0BAD_F00D, 4'hF, q, e, lat);
    model_write(32'h0, 32'h0BAD_F00D, 4'hF);
    txn(0, 1, 32'h0000_1000, 32'h0, 4'hF, q, e, lat);
    vectors++; if (q !== model_read(32'h0000_1000)) begin miscompares++; $display("FAIL oor_read_data got %h expected %h", q, model_read(32'h0000_1000)); end
    vectors++; if (e !== addr_oor(32'h0000_1000)) begin miscompares++; $display("FAIL oor_read_err got %b expected %b", e, addr_oor(32'h0000_1000)); end
    txn(1, 0, 32'h0000_1000, w, 4'hF, q, e, lat);
    model_write(32'h0000_1000, w, 4'hF);
    vectors++; if (e !== addr_oor(32'h0000_1000)) begin miscompares++; $display("FAIL oor_write_err got %b expected %b", e, addr_oor(32'h0000_1000)); end
    txn(0, 1, 32'h0, 32'h0, 4'hF, q, e, lat);
    vectors++; if (q !== model_read(32'h0)) begin miscompares++; $display("FAIL oor_write_effect got %h expected %h", q, model_read(32'h0)); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL inrange_err got %b expected 0", e); end
    last_read = q;
  endtask

  task automatic test_random();
    logic [31:0] q, a, d, exp; logic e; int lat; int op; logic [3:0] s;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      a = 32'(i * 4);
      txn(1, 0, a, d, 4'hF, q, e, lat);
      model_write(a, d, 4'hF);
    end
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 5);
      a = {22'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (op <= 1) begin
        txn(1, 0, a, d, s, q, e, lat);
        model_write(a, d, s);
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL rand_write_lat n=%0d got %0d expected 1", n, lat); end
      end else if (op <= 4) begin
        exp = model_read(a);
        txn(0, 1, a, d, s, q, e, lat);
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL rand_read_lat n=%0d got %0d expected 2", n, lat); end
        vectors++; if (q !== exp || e !== 1'b0) begin miscompares++; $display("FAIL rand_read n=%0d addr %h got %h/%b expected %h/0", n, a, q, e, exp); end
        last_read = exp;
      end else begin
        txn(1, 1, a, d, s, q, e, lat);
        model_write(a, d, s);
        vectors++; if (lat != 1 || q !== last_read) begin miscompares++; $display("FAIL rand_collision n=%0d got %h lat %0d expected %h lat 1", n, q, lat, last_read); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    last_read = '0;
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_collision();
    test_held_request();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
